// File: rtl/mux_lut_pipe_if.sv
// mux_lut_pipe_if: bundles the lookup stream and the serial table-load
// port of mux_lut_pipe.
//   master : drives in_valid/in_sel and cfg_start/cfg_valid/cfg_bit,
//            receives out_valid/out_data and cfg_busy
//   slave  : the lookup cell itself (opposite directions)
// K = function inputs per lane, W = number of lanes.
interface mux_lut_pipe_if #(
   parameter int unsigned K = 2,
   parameter int unsigned W = 8
);
   logic             in_valid;
   logic [W*K-1:0]   in_sel;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic             cfg_start;
   logic             cfg_valid;
   logic             cfg_bit;
   logic             cfg_busy;

   modport master (
      output in_valid, in_sel, cfg_start, cfg_valid, cfg_bit,
      input  out_valid, out_data, cfg_busy
   );

   modport slave (
      input  in_valid, in_sel, cfg_start, cfg_valid, cfg_bit,
      output out_valid, out_data, cfg_busy
   );
endinterface

// File: rtl/mux_lut_pipe.sv
// mux_lut_pipe: W-lane, K-input reprogrammable lookup cell. Every lane
// evaluates the same 2^K-entry truth table through a K-level tree of 2:1
// muxes; the result is registered (1-cycle latency, no backpressure).
// The table is shifted in serially (MSB first) into a shadow register and
// committed to the active table in one edge, so lookups never see a
// partially loaded table.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_lut_pipe_if.slave (in_valid/in_sel -> out_valid/out_data,
//           cfg_start/cfg_valid/cfg_bit -> cfg_busy)

// Single 2:1 mux leaf cell used to build the lookup trees.
module mux_lut_pipe_mux2 (
   input  logic i_a0,
   input  logic i_a1,
   input  logic i_s,
   output logic o_y
);
   assign o_y = i_s ? i_a1 : i_a0;
endmodule

module mux_lut_pipe #(
   parameter int unsigned K = 2,
   parameter int unsigned W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   mux_lut_pipe_if.slave  bus
);
   localparam int unsigned N  = 1 << K;
   localparam int unsigned CW = $clog2(N) + 1;
   // Every lane computes NOT of its selector bit 0 out of reset.
   localparam logic [N-1:0] RST_TBL = {(N/2){2'b01}};

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_LOAD = 1'b1
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [N-1:0]    r_shadow, w_shadow_nxt;
   logic [N-1:0]    r_active, w_active_nxt;
   logic [N-1:0]    w_shift;
   logic [W-1:0]    w_lut;
   logic            r_out_valid;
   logic [W-1:0]    r_out_data;

   assign w_shift = {r_shadow[N-2:0], bus.cfg_bit};

   // ---------------- table-load FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_RUN;
         r_cnt    <= '0;
         r_shadow <= '0;
         r_active <= RST_TBL;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_shadow <= w_shadow_nxt;
         r_active <= w_active_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_shadow_nxt = r_shadow;
      w_active_nxt = r_active;
      unique case (r_state)
         ST_RUN: begin
            if (bus.cfg_start) begin
               w_state_nxt  = ST_LOAD;
               w_cnt_nxt    = '0;
               w_shadow_nxt = '0;
            end
         end
         ST_LOAD: begin
            // A restart wins over a coincident data bit, which is dropped.
            if (bus.cfg_start) begin
               w_cnt_nxt    = '0;
               w_shadow_nxt = '0;
            end else if (bus.cfg_valid) begin
               w_shadow_nxt = w_shift;
               w_cnt_nxt    = r_cnt + CW'(1);
               // Last bit goes straight into the active table on this edge.
               if (r_cnt == CW'(N - 1)) begin
                  w_active_nxt = w_shift;
                  w_state_nxt  = ST_RUN;
               end
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign bus.cfg_busy = (r_state == ST_LOAD);

   // ---------------- lookup mux trees ----------------
   // Level i halves the candidate set using selector bit i; level 0 reads
   // the active table directly.
   for (genvar l = 0; l < W; l++) begin : g_lane
      logic [K-1:0] w_sel;
      assign w_sel = bus.in_sel[l*K +: K];

      for (genvar i = 0; i < K; i++) begin : g_lvl
         localparam int unsigned M = N >> (i + 1);
         logic [2*M-1:0] w_in;
         logic [M-1:0]   w_node;

         if (i == 0) begin : g_leaf
            assign w_in = r_active;
         end else begin : g_inner
            assign w_in = g_lvl[i-1].w_node;
         end

         for (genvar m = 0; m < M; m++) begin : g_mux
            mux_lut_pipe_mux2 u_mux (
               .i_a0 (w_in[2*m]),
               .i_a1 (w_in[2*m+1]),
               .i_s  (w_sel[i]),
               .o_y  (w_node[m])
            );
         end
      end

      assign w_lut[l] = g_lvl[K-1].w_node[0];
   end

   // ---------------- output register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_out_data <= w_lut;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_mux_lut_pipe.sv
// tb_mux_lut_pipe: self-checking bench for mux_lut_pipe. Three instances
// (K=2/W=8, K=1/W=1, K=3/W=4) share clock and reset; the K=2 instance is
// tracked by a queue-based reference of the load protocol, the others by
// direct Boolean expectations.
module tb_mux_lut_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_lut_pipe_if #(.K(2), .W(8)) a ();
   mux_lut_pipe_if #(.K(1), .W(1)) b ();
   mux_lut_pipe_if #(.K(3), .W(4)) c ();

   mux_lut_pipe #(.K(2), .W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
   mux_lut_pipe #(.K(1), .W(1)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));
   mux_lut_pipe #(.K(3), .W(4)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(c.slave));

   int n_checks = 0;
   int n_fail   = 0;

   // reference state for instance a
   logic [3:0] m_tbl;
   bit         m_loading;
   bit         m_q[$];
   logic [7:0] m_out;
   logic       m_valid;

   function automatic logic [7:0] lut2(input logic [3:0] t, input logic [15:0] s);
      logic [7:0] r;
      for (int l = 0; l < 8; l++) r[l] = t[s[2*l +: 2]];
      return r;
   endfunction

   task automatic model_reset();
      m_tbl = 4'b0101; m_loading = 0; m_q.delete(); m_out = '0; m_valid = 0;
   endtask

   // Advance one clock on instance a, updating the reference from the
   // inputs currently driven.
   task automatic tick();
      if (a.in_valid) begin m_out = lut2(m_tbl, a.in_sel); m_valid = 1; end
      else m_valid = 0;
      if (!m_loading) begin
         if (a.cfg_start) begin m_loading = 1; m_q.delete(); end
      end else if (a.cfg_start) begin
         m_q.delete();
      end else if (a.cfg_valid) begin
         m_q.push_back(a.cfg_bit);
         if (m_q.size() == 4) begin
            m_tbl = {m_q[0], m_q[1], m_q[2], m_q[3]};
            m_loading = 0;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_all();
      a.in_valid = 0; a.in_sel = '0; a.cfg_start = 0; a.cfg_valid = 0; a.cfg_bit = 0;
      b.in_valid = 0; b.in_sel = '0; b.cfg_start = 0; b.cfg_valid = 0; b.cfg_bit = 0;
      c.in_valid = 0; c.in_sel = '0; c.cfg_start = 0; c.cfg_valid = 0; c.cfg_bit = 0;
   endtask

   task automatic do_reset();
      idle_all();
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic send_cfg(input bit v);
      a.cfg_valid = 1; a.cfg_bit = v; tick(); a.cfg_valid = 0;
   endtask

   task automatic test_reset();
      idle_all();
      rst_n = 0; model_reset();
      #3;
      n_checks++; if (a.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", a.cfg_busy); end
      n_checks++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", a.out_valid); end
      n_checks++; if (a.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", a.out_data); end
      @(posedge clk); #1 rst_n = 1;
      a.in_valid = 1; a.in_sel = 16'hE4E4; tick();
      n_checks++; if (a.out_valid !== 1'b1) begin n_fail++; $display("FAIL default_valid got %b exp 1", a.out_valid); end
      n_checks++; if (a.out_data !== 8'h55 || m_out !== 8'h55) begin n_fail++; $display("FAIL default_not got %h exp 55", a.out_data); end
      a.in_valid = 0; a.in_sel = 16'h0000; tick();
      n_checks++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b exp 0", a.out_valid); end
      n_checks++; if (a.out_data !== 8'h55) begin n_fail++; $display("FAIL idle_hold got %h exp 55", a.out_data); end
   endtask

   task automatic test_xor_load();
      bit bits[4] = '{0, 1, 1, 0};
      int busy_cnt = 0;
      a.cfg_start = 1; tick(); a.cfg_start = 0;
      if (a.cfg_busy) busy_cnt++;
      foreach (bits[i]) begin
         send_cfg(bits[i]);
         if (a.cfg_busy) busy_cnt++;
         n_checks++; if (a.cfg_busy !== m_loading) begin n_fail++; $display("FAIL xor_busy bit%0d got %b exp %b", i, a.cfg_busy, m_loading); end
      end
      n_checks++; if (busy_cnt != 4) begin n_fail++; $display("FAIL xor_busy_cycles got %0d exp 4", busy_cnt); end
      a.in_valid = 1; a.in_sel = 16'hE4E4; tick(); a.in_valid = 0;
      n_checks++; if (a.out_data !== 8'b01100110 || a.out_data !== m_out) begin n_fail++; $display("FAIL xor_lookup got %h exp 66", a.out_data); end
   endtask

   task automatic test_commit_boundary();
      bit bits[4] = '{1, 0, 0, 0};
      do_reset();
      a.in_valid = 1; a.in_sel = 16'h0000;
      a.cfg_start = 1; tick(); a.cfg_start = 0;
      foreach (bits[i]) begin
         send_cfg(bits[i]);
         n_checks++; if (a.out_data !== m_out) begin n_fail++; $display("FAIL boundary_stream bit%0d got %h exp %h", i, a.out_data, m_out); end
      end
      n_checks++; if (a.out_data !== 8'hFF) begin n_fail++; $display("FAIL boundary_old got %h exp ff", a.out_data); end
      n_checks++; if (a.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL boundary_busy got %b exp 0", a.cfg_busy); end
      tick();
      n_checks++; if (a.out_data !== 8'h00) begin n_fail++; $display("FAIL boundary_new got %h exp 00", a.out_data); end
      a.in_valid = 0;
   endtask

   task automatic test_gaps_restart();
      bit gbits[4] = '{1, 0, 0, 1};
      bit obits[4] = '{1, 1, 1, 0};
      a.cfg_start = 1; tick(); a.cfg_start = 0;
      foreach (gbits[i]) begin
         repeat (3) begin
            tick();
            n_checks++; if (a.cfg_busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy bit%0d got %b exp 1", i, a.cfg_busy); end
         end
         send_cfg(gbits[i]);
      end
      n_checks++; if (a.cfg_busy !== 1'b0 || m_tbl !== 4'b1001) begin n_fail++; $display("FAIL gap_commit busy %b exp 0", a.cfg_busy); end
      a.in_valid = 1; a.in_sel = 16'hE4E4; tick(); a.in_valid = 0;
      n_checks++; if (a.out_data !== 8'h99) begin n_fail++; $display("FAIL gap_lookup got %h exp 99", a.out_data); end
      // restart after two bits; the restart cycle also carries a bit that must be dropped
      a.cfg_start = 1; tick(); a.cfg_start = 0;
      send_cfg(0); send_cfg(0);
      a.cfg_start = 1; a.cfg_valid = 1; a.cfg_bit = 0; tick(); a.cfg_start = 0; a.cfg_valid = 0;
      foreach (obits[i]) send_cfg(obits[i]);
      n_checks++; if (a.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL restart_busy got %b exp 0", a.cfg_busy); end
      a.in_valid = 1; a.in_sel = 16'hE4E4; tick(); a.in_valid = 0;
      n_checks++; if (a.out_data !== 8'hEE || a.out_data !== m_out) begin n_fail++; $display("FAIL restart_or got %h exp ee", a.out_data); end
   endtask

   task automatic test_reset_mid_load();
      a.in_valid = 1; a.in_sel = 16'hE4E4;
      a.cfg_start = 1; tick(); a.cfg_start = 0;
      send_cfg(1); send_cfg(1);
      rst_n = 0; model_reset(); idle_all();
      #2;
      n_checks++; if (a.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b exp 0", a.cfg_busy); end
      n_checks++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b exp 0", a.out_valid); end
      @(posedge clk); #1 rst_n = 1;
      a.in_valid = 1; a.in_sel = 16'h5555; tick(); a.in_valid = 0;
      n_checks++; if (a.out_data !== 8'h00 || a.out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_not got %h v%b exp 00 v1", a.out_data, a.out_valid); end
      tick();
      n_checks++; if (a.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_state busy %b exp 0", a.cfg_busy); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         a.in_valid  = ($urandom_range(0, 3) != 0);
         a.in_sel    = 16'($urandom);
         a.cfg_start = ($urandom_range(0, 24) == 0);
         a.cfg_valid = $urandom_range(0, 1);
         a.cfg_bit   = $urandom_range(0, 1);
         tick();
         n_checks++; if (a.out_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid cyc%0d got %b exp %b", n, a.out_valid, m_valid); end
         n_checks++; if (a.out_data !== m_out) begin n_fail++; $display("FAIL rand_data cyc%0d got %h exp %h", n, a.out_data, m_out); end
         n_checks++; if (a.cfg_busy !== m_loading) begin n_fail++; $display("FAIL rand_busy cyc%0d got %b exp %b", n, a.cfg_busy, m_loading); end
      end
      idle_all();
   endtask

   task automatic test_k1_not();
      logic s;
      for (int n = 0; n < 8; n++) begin
         s = (n < 2) ? n[0] : 1'($urandom);
         b.in_valid = 1; b.in_sel = s;
         @(posedge clk); #1;
         n_checks++; if (b.out_data !== ~s || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL k1_not sel %b got %b exp %b", s, b.out_data, ~s); end
      end
      b.in_valid = 0;
   endtask

   task automatic test_k3_majority();
      logic [7:0]  maj = 8'b11101000;
      logic [3:0]  e_out = '0;
      logic [11:0] s;
      logic        e_valid;
      c.cfg_start = 1; @(posedge clk); #1; c.cfg_start = 0;
      for (int i = 7; i >= 0; i--) begin
         c.cfg_valid = 1; c.cfg_bit = maj[i]; @(posedge clk); #1;
      end
      c.cfg_valid = 0;
      n_checks++; if (c.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL k3_busy got %b exp 0", c.cfg_busy); end
      for (int n = 0; n < 1000; n++) begin
         s = 12'($urandom);
         c.in_valid = ($urandom_range(0, 4) != 0);
         c.in_sel = s;
         e_valid = c.in_valid;
         if (c.in_valid)
            for (int l = 0; l < 4; l++)
               e_out[l] = (int'(s[3*l]) + int'(s[3*l+1]) + int'(s[3*l+2])) >= 2;
         @(posedge clk); #1;
         n_checks++; if (c.out_data !== e_out || c.out_valid !== e_valid) begin n_fail++; $display("FAIL k3_maj cyc%0d got %h v%b exp %h v%b", n, c.out_data, c.out_valid, e_out, e_valid); end
      end
      c.in_valid = 0;
   endtask

   initial begin
      idle_all();
      model_reset();
      test_reset();
      test_xor_load();
      test_commit_boundary();
      test_gaps_restart();
      test_reset_mid_load();
      test_random();
      do_reset();
      test_k1_not();
      test_k3_majority();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mux_lut_pipe.md
# mux_lut_pipe

Parametrised, registered lookup-table unit that computes any K-input Boolean function on W independent lanes, with the function built from 2:1 mux trees selected by the input bits. The truth table is loaded serially at run time into a shadow register and committed atomically, so the datapath never sees a partial table. It generalises the team's fixed mux-built gates, such as NOT from a mux, into one reprogrammable, pipelined cell. Downstream logic consumes `out_data` under `out_valid`.

## Interface
- `K`, default 2: function inputs per lane. Legal range 1..6. Truth table is 2^K bits.
- `W`, default 8: number of parallel lanes sharing one truth table.
- `clk`  input  1: single clock, all state on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `in_valid`  input  1: `in_sel` is valid this cycle.
- `in_sel`  input  W*K: lane n selector is bits [n*K+K-1 : n*K].
- `out_valid`  output  1: `out_data` is valid.
- `out_data`  output  W: bit n = active_table[lane n selector].
- `cfg_start`  input  1: pulse that begins a table load.
- `cfg_valid`  input  1: `cfg_bit` is valid this cycle.
- `cfg_bit`  input  1: serial truth-table bit, MSB (index 2^K-1) first.
- `cfg_busy`  output  1: high while in LOAD.

## Operation
- **Lookup datapath**
  - Each lane is a K-level tree of 2:1 mux instances. Leaves are `active_table` bits; level i selects on selector bit i.
  - A behavioural array index is not acceptable.
- **Tables**
  - `active_table` (2^K bits) drives the datapath.
  - `shadow_table` (2^K bits) receives serial bits.
  - Bit counter is clog2(2^K)+1 bits wide.
- **Reset table**: `active_table[j] = ~j[0]`, i.e. every lane computes NOT of selector bit 0. For K=2 this is 4'b0101.
- **FSM states**: RUN and LOAD. Reset state is RUN.
- **RUN**
  - `cfg_start` moves to LOAD and clears the counter.
  - `cfg_valid` is ignored.
- **LOAD**
  - Each `cfg_valid` cycle: `shadow_table <= {shadow_table[2^K-2:0], cfg_bit}` and the counter increments.
  - On the cycle that samples bit number 2^K: `active_table <= {shadow_table[2^K-2:0], cfg_bit}`, then return to RUN.
  - `cfg_start` in LOAD restarts the load: counter cleared and partial shadow discarded. If `cfg_valid` is also high that cycle, the bit is dropped.
  - `cfg_valid` low stalls the load indefinitely; there is no timeout.
- **Datapath vs FSM**: the datapath keeps operating in both states using `active_table`. Loading never stalls or drops data.
- **K=1**: the table is 2 bits and the tree is a single mux.

## Timing
- **Latency**: 1 cycle. At the edge where `in_valid`=1, `out_valid` goes to 1 and `out_data` takes the lookup result, both registered.
- **Idle cycles**: if `in_valid`=0 at an edge, `out_valid` goes to 0 and `out_data` holds its previous value.
- **Throughput**: one vector per cycle. There is no backpressure.
- **Commit boundary**
  - Input sampled on the same edge as the final config bit uses the OLD table.
  - Input sampled on the next edge uses the NEW table.
  - `cfg_busy` falls at the commit edge.
- **`cfg_busy`** rises at the edge that samples `cfg_start` in RUN.
- **Reset values**: `out_valid`=0, `out_data`=0, `cfg_busy`=0, state RUN, counter 0, `shadow_table`=0, `active_table` = reset table.
- **Reset mid-load**: an aborted load is discarded and `active_table` returns to the reset table, not the last committed one.

## Test plan
- **Reset default (K=2, W=8)**: after reset, drive `in_valid`=1 with lane selectors 0,1,2,3,0,1,2,3 → next cycle `out_data`=8'b01010101 with lane 0 in the LSB, `out_valid`=1.
- **XOR load**
  - Stimulus: `cfg_start`, then bits 0,1,1,0 on consecutive `cfg_valid` cycles.
  - `cfg_busy` is high for 4 cycles.
  - Then the same selectors → `out_data`=8'b01100110.
- **Commit boundary**: stream `in_valid`=1, selector 0 on all lanes, during an AND load (bits 1,0,0,0).
  - Output for input on the final-bit edge is 8'hFF (old NOT table).
  - Output for the next input is 8'h00.
- **Gaps and restart**
  - Load with `cfg_valid` gaps of 3 cycles → commits only after 4 valid bits.
  - `cfg_start` after 2 bits, then 4 bits of 4'b1110 (OR) → OR table committed and earlier bits ignored.
- **Reset mid-load**: assert `rst_n`=0 after 2 of 4 bits → `cfg_busy`=0, `out_valid`=0, and the table is NOT again (selector 1 → 0).
- **Parameter sweep**: K=1, W=1 (reset table gives a NOT gate), and K=3, W=4 with an 8-bit majority table 8'b11101000 → random selectors match a reference model over 1000 cycles.
